vex_stage: RTL and testbench

Execute stage of the vector processor pipeline, sitting directly downstream of the decode/execute pipeline register and feeding the memory stage. It executes scalar ALU operations in one cycle. It executes 128-bit vector operations over four cycles, one 32-bit lane per cycle, through a single shared lane ALU. While a vector operation is in flight it stalls the upstream stages. Results are registered into the execute/memory pipeline register.

---
 rtl/vp_pkg.sv | 24 ++
 rtl/vex_stage_lane_alu.sv | 35 +++
 rtl/vex_stage.sv | 166 ++++++++++++++++
 tb/tb_vex_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types for the vector pipeline: ALU opcode encoding, default geometry
// and the execute-stage FSM state.
package vp_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vex_state_e;

endpackage

// File: rtl/vex_stage_lane_alu.sv
// Combinational lane ALU shared by the scalar path and every vector lane.
// Define VEX_MUL_EN to build the multiplier; otherwise opcode MUL yields 0.
module lane_alu
    import vp_pkg::*;
#(
    parameter int W = LANE_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SLL: y = a << b[4:0];
            OP_SRL: y = a >> b[4:0];
            OP_MUL: begin
`ifdef VEX_MUL_EN
                y = a * b;
`else
                y = '0;
`endif
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vex_stage.sv
// Execute stage: one-cycle scalar ops, vector ops one lane per cycle through a
// single lane_alu. Optional multiplier is enabled by defining VEX_MUL_EN.
module vex_stage
    import vp_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    regw_E,
    input  logic                    memw_E,
    input  logic                    regmem_E,
    input  logic                    ALUope_E,
    input  logic                    vec_E,
    input  logic [2:0]              ALUctrl_E,
    input  logic [3:0]              regScr_E,
    input  logic [LANE_W-1:0]       regA_E,
    input  logic [LANE_W-1:0]       regB_E,
    input  logic [LANE_W-1:0]       inm_E,
    input  logic [LANES*LANE_W-1:0] regVA_E,
    input  logic [LANES*LANE_W-1:0] regVB_E,
    output logic                    stall_E,
    output logic                    regw_M,
    output logic                    memw_M,
    output logic                    regmem_M,
    output logic                    vec_M,
    output logic [3:0]              regDst_M,
    output logic [LANE_W-1:0]       aluRes_M,
    output logic [LANES*LANE_W-1:0] vecRes_M,
    output logic [LANE_W-1:0]       wdata_M,
    output vex_state_e              state_dbg
);

    localparam int VW = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    vex_state_e        state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [VW-1:0]     va_q, vb_q, res_buf, vec_done;
    alu_op_e           op_q;
    logic              regw_q, memw_q, regmem_q;
    logic [3:0]        dst_q;
    logic [LANE_W-1:0] alu_a, alu_b, alu_y;
    alu_op_e           alu_op;
    logic              start, last_lane;

    assign state_dbg = state;
    assign start     = (state == ST_IDLE) && vec_E;
    assign last_lane = (state == ST_RUN) && (cnt == LAST);

    // Operand mux: latched lane in RUN, lane 0 of the live inputs on a vector
    // start, scalar operands otherwise. Broadcast is already folded into vb_q.
    always_comb begin
        alu_a  = regA_E;
        alu_b  = ALUope_E ? inm_E : regB_E;
        alu_op = alu_op_e'(ALUctrl_E);
        if (state == ST_RUN) begin
            alu_a  = va_q[cnt*LANE_W +: LANE_W];
            alu_b  = vb_q[cnt*LANE_W +: LANE_W];
            alu_op = op_q;
        end else if (vec_E) begin
            alu_a = regVA_E[LANE_W-1:0];
            alu_b = ALUope_E ? inm_E : regVB_E[LANE_W-1:0];
        end
    end

    lane_alu #(.W(LANE_W)) u_lane_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    always_comb begin
        vec_done = res_buf;
        vec_done[cnt*LANE_W +: LANE_W] = alu_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_E   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vec_E) begin
                    state_nxt = ST_RUN;
                    stall_E   = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) state_nxt = ST_IDLE;
                else             stall_E   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) stall_E = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            res_buf  <= '0;
            op_q     <= OP_ADD;
            regw_q   <= 1'b0;
            memw_q   <= 1'b0;
            regmem_q <= 1'b0;
            dst_q    <= '0;
        end else if (start) begin
            va_q     <= regVA_E;
            vb_q     <= ALUope_E ? {LANES{inm_E}} : regVB_E;
            op_q     <= alu_op_e'(ALUctrl_E);
            regw_q   <= regw_E;
            memw_q   <= memw_E;
            regmem_q <= regmem_E;
            dst_q    <= regScr_E;
            res_buf[LANE_W-1:0] <= alu_y;
            cnt      <= CW'(1);
        end else if (state == ST_RUN) begin
            res_buf[cnt*LANE_W +: LANE_W] <= alu_y;
            cnt <= last_lane ? '0 : cnt + 1'b1;
        end
    end

    // Bubbles while stalled; data outputs keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regw_M   <= 1'b0;
            memw_M   <= 1'b0;
            regmem_M <= 1'b0;
            vec_M    <= 1'b0;
            regDst_M <= '0;
            aluRes_M <= '0;
            vecRes_M <= '0;
            wdata_M  <= '0;
        end else if (stall_E) begin
            regw_M   <= 1'b0;
            memw_M   <= 1'b0;
            regmem_M <= 1'b0;
            vec_M    <= 1'b0;
        end else if (last_lane) begin
            regw_M   <= regw_q;
            memw_M   <= memw_q;
            regmem_M <= regmem_q;
            vec_M    <= 1'b1;
            regDst_M <= dst_q;
            vecRes_M <= vec_done;
        end else begin
            regw_M   <= regw_E;
            memw_M   <= memw_E;
            regmem_M <= regmem_E;
            vec_M    <= 1'b0;
            regDst_M <= regScr_E;
            aluRes_M <= alu_y;
            wdata_M  <= regB_E;
        end
    end

endmodule

// File: tb/tb_vex_stage.sv
// Directed scoreboard bench for vex_stage: drivers push expected results,
// a negedge monitor pops and compares whenever a non-bubble output appears.
module tb_vex_stage;
    import vp_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         regw_E, memw_E, regmem_E, ALUope_E, vec_E;
    logic [2:0]   ALUctrl_E;
    logic [3:0]   regScr_E;
    logic [31:0]  regA_E, regB_E, inm_E;
    logic [127:0] regVA_E, regVB_E;
    logic         stall_E, regw_M, memw_M, regmem_M, vec_M;
    logic [3:0]   regDst_M;
    logic [31:0]  aluRes_M, wdata_M;
    logic [127:0] vecRes_M;
    vex_state_e   state_dbg;

    vex_stage #(.LANES(4), .LANE_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .regw_E    (regw_E),
        .memw_E    (memw_E),
        .regmem_E  (regmem_E),
        .ALUope_E  (ALUope_E),
        .vec_E     (vec_E),
        .ALUctrl_E (ALUctrl_E),
        .regScr_E  (regScr_E),
        .regA_E    (regA_E),
        .regB_E    (regB_E),
        .inm_E     (inm_E),
        .regVA_E   (regVA_E),
        .regVB_E   (regVB_E),
        .stall_E   (stall_E),
        .regw_M    (regw_M),
        .memw_M    (memw_M),
        .regmem_M  (regmem_M),
        .vec_M     (vec_M),
        .regDst_M  (regDst_M),
        .aluRes_M  (aluRes_M),
        .vecRes_M  (vecRes_M),
        .wdata_M   (wdata_M),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  alu;
        logic [127:0] vec;
        logic [3:0]   ctrl;
        logic [3:0]   dst;
        logic [31:0]  wdata;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    logic [31:0]  m_alu = '0;
    logic [31:0]  m_wdata = '0;
    logic [127:0] m_vec = '0;

`ifdef VEX_MUL_EN
    localparam logic [31:0] MUL_3X5 = 32'd15;
`else
    localparam logic [31:0] MUL_3X5 = 32'd0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (regw_M || memw_M || regmem_M || vec_M)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_output: got ctrl %b with empty queue expected none",
                         {regw_M, memw_M, regmem_M, vec_M});
            end else begin
                mon_e = exp_q.pop_front();
                check("ctrl",   {regw_M, memw_M, regmem_M, vec_M}, mon_e.ctrl);
                check("dst",    regDst_M, mon_e.dst);
                check("aluRes", aluRes_M, mon_e.alu);
                check("vecRes", vecRes_M, mon_e.vec);
                check("wdata",  wdata_M,  mon_e.wdata);
            end
        end
    end

    task automatic drive_nop();
        regw_E = 0; memw_E = 0; regmem_E = 0; ALUope_E = 0; vec_E = 0;
        ALUctrl_E = 0; regScr_E = 0; regA_E = 0; regB_E = 0; inm_E = 0;
        regVA_E = 0; regVB_E = 0;
    endtask

    // Holds the current instruction until stall_E is low at a negedge, then
    // steps to just after the next rising edge.
    task automatic wait_accept(input string name, input int exp_stalls);
        int  n = 0;
        bit  done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (stall_E) n++;
            else done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got stall stuck high expected release", name);
        end
        check(name, n, exp_stalls);
        @(posedge clk);
        #1;
    endtask

    task automatic issue_s(input logic [2:0] op, input logic ope, input logic [2:0] rwm,
                           input logic [3:0] dst, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic [31:0] exp_res);
        exp_t e;
        drive_nop();
        {regw_E, memw_E, regmem_E} = rwm;
        ALUctrl_E = op; ALUope_E = ope; regScr_E = dst;
        regA_E = a; regB_E = b; inm_E = im;
        m_alu = exp_res;
        m_wdata = b;
        e = '{alu: m_alu, vec: m_vec, ctrl: {rwm, 1'b0}, dst: dst, wdata: m_wdata};
        exp_q.push_back(e);
        wait_accept("scalar_stall_cycles", 0);
    endtask

    task automatic set_vec(input logic [2:0] op, input logic ope, input logic [2:0] rwm,
                           input logic [3:0] dst, input logic [127:0] va, input logic [127:0] vb,
                           input logic [31:0] im);
        drive_nop();
        {regw_E, memw_E, regmem_E} = rwm;
        vec_E = 1; ALUctrl_E = op; ALUope_E = ope; regScr_E = dst;
        regVA_E = va; regVB_E = vb; inm_E = im;
        regA_E = 32'hDEAD0001; regB_E = 32'hDEAD0002;
    endtask

    task automatic issue_v(input logic [2:0] op, input logic ope, input logic [2:0] rwm,
                           input logic [3:0] dst, input logic [127:0] va, input logic [127:0] vb,
                           input logic [31:0] im, input logic [127:0] exp_vec);
        exp_t e;
        set_vec(op, ope, rwm, dst, va, vb, im);
        m_vec = exp_vec;
        e = '{alu: m_alu, vec: m_vec, ctrl: {rwm, 1'b1}, dst: dst, wdata: m_wdata};
        exp_q.push_back(e);
        wait_accept("vector_stall_cycles", 3);
    endtask

    initial begin
        drive_nop();
        vec_E = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",  stall_E, 0);
        check("rst_ctrl",   {regw_M, memw_M, regmem_M, vec_M}, 0);
        check("rst_vecRes", vecRes_M, 0);
        check("rst_aluRes", aluRes_M, 0);
        check("rst_state",  state_dbg, ST_IDLE);
        vec_E = 0;
        rst = 0;
        @(posedge clk);
        #1;

        issue_s(3'b000, 0, 3'b100, 4'd3, 32'h0000FFFF, 32'h00000801, 32'h0, 32'h00010800);
        issue_s(3'b101, 1, 3'b100, 4'd5, 32'h0000FFFF, 32'h00001234, 32'h4, 32'h000FFFF0);
        issue_v(3'b000, 0, 3'b100, 4'd2,
                128'hFFFFFFFF_00000003_00000002_00000001,
                128'h00000001_00000001_00000001_00000001, 32'h0,
                128'h00000000_00000004_00000003_00000002);
        issue_v(3'b100, 1, 3'b100, 4'd6,
                128'hA5A5A5A5_0F0F0F0F_FFFF0000_12345678,
                128'h00000000_00000000_00000000_00000001, 32'hFFFFFFFF,
                128'h5A5A5A5A_F0F0F0F0_0000FFFF_EDCBA987);
        issue_s(3'b001, 0, 3'b100, 4'd4, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE);
        issue_s(3'b010, 0, 3'b010, 4'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000);
        issue_s(3'b011, 0, 3'b101, 4'd9, 32'h12340000, 32'h00005678, 32'h0, 32'h12345678);
        issue_s(3'b110, 0, 3'b100, 4'd10, 32'h80000000, 32'h00000023, 32'h0, 32'h10000000);
        issue_s(3'b111, 0, 3'b100, 4'd11, 32'h00010000, 32'h00010000, 32'h0, 32'h00000000);
        issue_s(3'b111, 0, 3'b100, 4'd12, 32'd3, 32'd5, 32'h0, MUL_3X5);
        issue_v(3'b001, 0, 3'b101, 4'd7,
                128'h00000028_0000001E_00000014_0000000A,
                128'h00000004_00000003_00000002_00000001, 32'h0,
                128'h00000024_0000001B_00000012_00000009);
        issue_v(3'b101, 1, 3'b100, 4'd8,
                128'h00000004_00000003_00000002_00000001,
                128'h0, 32'h8,
                128'h00000400_00000300_00000200_00000100);

        // Abort a vector op one cycle in; it must leave no result behind.
        set_vec(3'b000, 0, 3'b100, 4'd2,
                128'h00000001_00000001_00000001_00000001,
                128'h00000001_00000001_00000001_00000001, 32'h0);
        @(posedge clk);
        #1;
        check("abort_running", state_dbg, ST_RUN);
        rst = 1;
        #1;
        check("abort_stall",  stall_E, 0);
        check("abort_ctrl",   {regw_M, memw_M, regmem_M, vec_M}, 0);
        check("abort_dst",    regDst_M, 0);
        check("abort_aluRes", aluRes_M, 0);
        check("abort_vecRes", vecRes_M, 0);
        check("abort_wdata",  wdata_M, 0);
        check("abort_state",  state_dbg, ST_IDLE);
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_alu = '0;
        m_wdata = '0;
        m_vec = '0;
        @(posedge clk);
        #1;
        issue_s(3'b100, 0, 3'b100, 4'd13, 32'h000000FF, 32'h0000000F, 32'h0, 32'h000000F0);

        drive_nop();
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
